// File: rtl/pin_sampler_pkg.sv
// Shared definitions for the per-pin input sampler: register offsets, command
// codes, FSM states and status word bit positions.
package pin_sampler_pkg;

  localparam logic [20:0] OFF_DIV    = 21'd4;
  localparam logic [20:0] OFF_COUNT  = 21'd8;
  localparam logic [20:0] OFF_CTRL   = 21'd12;
  localparam logic [20:0] OFF_POP    = 21'd16;
  localparam logic [20:0] OFF_STATUS = 21'd20;

  localparam logic [15:0] CMD_START = 16'd1;
  localparam logic [15:0] CMD_STOP  = 16'd2;

  localparam int STAT_OVF_BIT = 15;
  localparam int STAT_RUN_BIT = 14;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a fill-level output. Push while full is refused
// unless a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [AW:0]   r_level;
  logic          w_doPush;
  logic          w_doPop;

  assign empty    = (r_level == '0);
  assign full     = (r_level == DEPTH);
  assign level    = r_level;
  assign dout     = r_mem[r_rdPtr];
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_doPush && !w_doPop) begin
        r_level <= r_level + 1'b1;
      end else if (w_doPop && !w_doPush) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pin_sampler.sv
// Samples one pin at a programmable rate, packs 16 samples per word (first
// sample in bit 0) and returns the words through a FIFO on the register bus.
module pin_sampler
  import pin_sampler_pkg::*;
#(
  parameter int POSITION = 0,
  parameter int FIFO_AW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [15:0] data_out,
  input  logic        pin_input,
  output logic        fifo_nonempty
);

  localparam logic [20:0] A_BASE   = 21'(POSITION);
  localparam logic [20:0] A_DIV    = A_BASE + OFF_DIV;
  localparam logic [20:0] A_COUNT  = A_BASE + OFF_COUNT;
  localparam logic [20:0] A_CTRL   = A_BASE + OFF_CTRL;
  localparam logic [20:0] A_POP    = A_BASE + OFF_POP;
  localparam logic [20:0] A_STATUS = A_BASE + OFF_STATUS;

  state_t r_state;
  state_t w_stateNext;
  logic   w_enterRun;

  logic r_sync1;
  logic r_sync2;

  logic [15:0] r_divReg;
  logic [15:0] r_countReg;
  logic        r_runInfReg;

  logic [15:0] r_divActive;
  logic        r_runInf;
  logic [15:0] r_wordsLeft;
  logic [15:0] r_divCnt;
  logic [3:0]  r_bitCnt;
  logic [15:0] r_shift;

  logic        r_ovf;
  logic [15:0] r_dataOut;

  logic               w_start;
  logic               w_stop;
  logic               w_sample;
  logic               w_wordDone;
  logic               w_lastWord;
  logic [15:0]        w_word;
  logic               w_popReq;
  logic               w_statRd;
  logic               w_ovfEvent;
  logic [15:0]        w_status;
  logic [15:0]        w_fifoDout;
  logic               w_fifoFull;
  logic               w_fifoEmpty;
  logic [FIFO_AW:0]   w_fifoLevel;

  assign w_start    = wr_en && (addr == '0) && (data_in == CMD_START);
  assign w_stop     = wr_en && (addr == '0) && (data_in == CMD_STOP);
  assign w_popReq   = rd_en && (addr == A_POP);
  assign w_statRd   = rd_en && (addr == A_STATUS);

  // A STOP cycle takes no sample, so a word finishing on that cycle is lost too.
  assign w_sample   = (r_state == S_RUN) && !w_stop && (r_divCnt == '0);
  assign w_wordDone = w_sample && (r_bitCnt == 4'd15);
  assign w_lastWord = w_wordDone && !r_runInf && (r_wordsLeft == 16'd1);
  assign w_word     = {r_sync2, r_shift[15:1]};
  assign w_ovfEvent = w_wordDone && w_fifoFull && !(w_popReq && !w_fifoEmpty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pin_input;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_divReg    <= '0;
      r_countReg  <= '0;
      r_runInfReg <= 1'b0;
    end else if (wr_en) begin
      if (addr == A_DIV) begin
        r_divReg <= data_in;
      end else if (addr == A_COUNT) begin
        r_countReg <= data_in;
      end else if (addr == A_CTRL) begin
        r_runInfReg <= data_in[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_enterRun  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && ((r_countReg != '0) || r_runInfReg)) begin
          w_stateNext = S_RUN;
          w_enterRun  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_stop || w_lastWord) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Run parameters are captured at START so bus writes mid-run stay pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divActive <= '0;
      r_runInf    <= 1'b0;
      r_wordsLeft <= '0;
      r_divCnt    <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
    end else if (w_enterRun) begin
      r_divActive <= (r_divReg == '0) ? 16'd1 : r_divReg;
      r_runInf    <= r_runInfReg;
      r_wordsLeft <= r_countReg;
      r_divCnt    <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
    end else if (w_sample) begin
      r_shift  <= w_word;
      r_bitCnt <= r_bitCnt + 4'd1;
      r_divCnt <= r_divActive - 16'd1;
      if (w_wordDone && !r_runInf) begin
        r_wordsLeft <= r_wordsLeft - 16'd1;
      end
    end else if (r_state == S_RUN) begin
      r_divCnt <= r_divCnt - 16'd1;
    end
  end

  sync_fifo #(
    .DW(16),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wordDone),
    .pop   (w_popReq),
    .din   (w_word),
    .dout  (w_fifoDout),
    .full  (w_fifoFull),
    .empty (w_fifoEmpty),
    .level (w_fifoLevel)
  );

  always_comb begin
    w_status               = 16'(w_fifoLevel);
    w_status[STAT_OVF_BIT] = r_ovf;
    w_status[STAT_RUN_BIT] = (r_state == S_RUN);
  end

  // A status read clears overflow, but an overflow in that same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_dataOut <= '0;
    end else begin
      if (w_statRd) begin
        r_ovf <= w_ovfEvent;
      end else if (w_ovfEvent) begin
        r_ovf <= 1'b1;
      end
      if (w_popReq) begin
        r_dataOut <= w_fifoEmpty ? 16'h0000 : w_fifoDout;
      end else if (w_statRd) begin
        r_dataOut <= w_status;
      end
    end
  end

  assign data_out      = r_dataOut;
  assign fifo_nonempty = !w_fifoEmpty;

endmodule

// File: tb/tb_pin_sampler.sv
// Bench for pin_sampler: directed scenarios followed by random bus and pin
// traffic, every cycle checked against a sample-schedule reference model.
module tb_pin_sampler;

  localparam int POS = 64;
  localparam int AW  = 4;
  localparam int CAP = 16;

  localparam logic [20:0] A_CMD    = 21'd0;
  localparam logic [20:0] A_DIV    = 21'(POS + 4);
  localparam logic [20:0] A_COUNT  = 21'(POS + 8);
  localparam logic [20:0] A_CTRL   = 21'(POS + 12);
  localparam logic [20:0] A_POP    = 21'(POS + 16);
  localparam logic [20:0] A_STATUS = 21'(POS + 20);
  localparam logic [15:0] START    = 16'd1;
  localparam logic [15:0] STOP     = 16'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] addr;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_out;
  logic        pin_input;
  logic        fifo_nonempty;

  int compared   = 0;
  int mismatched = 0;
  logic curPin   = 1'b0;

  // Reference model: runs are described by elapsed cycles since START.
  logic [15:0] mFifo[$];
  logic        pinHist[$];
  bit          mRun = 1'b0;
  int          mT, mD, mN, mDone;
  bit          mInf;
  logic [15:0] mPartial;
  logic [15:0] mDivReg, mNReg, mCtrlReg;
  bit          mOvf = 1'b0;
  logic [15:0] mDataOut = 16'h0000;

  always #10 clk = ~clk;

  pin_sampler #(
    .POSITION(POS),
    .FIFO_AW (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .pin_input    (pin_input),
    .fifo_nonempty(fifo_nonempty)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    logic        s;
    logic        pushV;
    logic [15:0] pushW;
    logic        ovfEv;
    logic        startNow;
    logic        stopNow;
    logic        endRun;
    int          k;
    if (reset) begin
      mRun = 1'b0;
      mFifo.delete();
      mOvf = 1'b0;
      mDataOut = 16'h0000;
      mDivReg = '0;
      mNReg = '0;
      mCtrlReg = '0;
      pinHist.delete();
      pinHist.push_back(1'b0);
      pinHist.push_back(1'b0);
      return;
    end
    s        = pinHist[pinHist.size()-2];
    stopNow  = mRun && wr_en && (addr == A_CMD) && (data_in == STOP);
    startNow = !mRun && wr_en && (addr == A_CMD) && (data_in == START) &&
               ((mNReg != 0) || mCtrlReg[0]);
    pushV  = 1'b0;
    pushW  = '0;
    endRun = 1'b0;
    if (mRun && !stopNow) begin
      if (mT % mD == 0) begin
        k = (mT / mD) % 16;
        mPartial[k] = s;
        if (k == 15) begin
          pushV = 1'b1;
          pushW = mPartial;
          mDone++;
          if (!mInf && mDone == mN) endRun = 1'b1;
        end
      end
      mT++;
    end
    if (rd_en && addr == A_STATUS) begin
      mDataOut = {mOvf, mRun, 9'd0, 5'(mFifo.size())};
    end
    if (rd_en && addr == A_POP) begin
      mDataOut = (mFifo.size() == 0) ? 16'h0000 : mFifo.pop_front();
    end
    ovfEv = 1'b0;
    if (pushV) begin
      if (mFifo.size() < CAP) mFifo.push_back(pushW);
      else ovfEv = 1'b1;
    end
    mOvf = (rd_en && addr == A_STATUS) ? ovfEv : (mOvf | ovfEv);
    if (wr_en && addr == A_DIV)   mDivReg  = data_in;
    if (wr_en && addr == A_COUNT) mNReg    = data_in;
    if (wr_en && addr == A_CTRL)  mCtrlReg = data_in;
    if (startNow) begin
      mRun = 1'b1;
      mT = 0;
      mD = (mDivReg == 0) ? 1 : int'(mDivReg);
      mInf = mCtrlReg[0];
      mN = int'(mNReg);
      mDone = 0;
      mPartial = '0;
    end
    if (stopNow || endRun) mRun = 1'b0;
    pinHist.push_back(pin_input);
    if (pinHist.size() > 4) void'(pinHist.pop_front());
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [20:0] a,
                               input logic [15:0] d, input logic p, input logic rst);
    wr_en = w;
    rd_en = r;
    addr = a;
    data_in = d;
    pin_input = p;
    reset = rst;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("data_out", data_out, mDataOut);
    checkOutput("fifo_nonempty", {15'd0, fifo_nonempty}, {15'd0, mFifo.size() != 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 21'd0, 16'd0, curPin, 1'b0);
  endtask

  task automatic writeReg(input logic [20:0] a, input logic [15:0] d);
    applyStimulus(1'b1, 1'b0, a, d, curPin, 1'b0);
  endtask

  task automatic readReg(input logic [20:0] a);
    applyStimulus(1'b0, 1'b1, a, 16'd0, curPin, 1'b0);
  endtask

  initial begin
    pinHist.push_back(1'b0);
    pinHist.push_back(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 21'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("reset_dout", data_out, 16'h0000);
    checkOutput("reset_nonempty", {15'd0, fifo_nonempty}, 16'h0000);
    idle(2);

    $display("[TB] single word, D=1");
    curPin = 1'b1;
    writeReg(A_DIV, 16'd1);
    writeReg(A_COUNT, 16'd1);
    writeReg(A_CTRL, 16'd0);
    writeReg(A_CMD, START);
    idle(15);
    readReg(A_STATUS);
    checkOutput("t1_status_running", data_out, 16'h4000);
    readReg(A_STATUS);
    checkOutput("t1_status_done", data_out, 16'h0001);
    readReg(A_POP);
    checkOutput("t1_pop", data_out, 16'hFFFF);
    readReg(A_STATUS);
    checkOutput("t1_status_empty", data_out, 16'h0000);

    $display("[TB] D=2 alternating pin, then D=0");
    writeReg(A_DIV, 16'd2);
    idle(1);
    writeReg(A_CMD, START);
    for (int j = 1; j <= 31; j++) begin
      curPin = (((j + 1) / 2) % 2 == 0);
      idle(1);
    end
    readReg(A_POP);
    checkOutput("t2_pop_5555", data_out, 16'h5555);
    curPin = 1'b1;
    writeReg(A_DIV, 16'd0);
    writeReg(A_CMD, START);
    idle(16);
    readReg(A_STATUS);
    checkOutput("t2_d0_status", data_out, 16'h0001);
    readReg(A_POP);
    checkOutput("t2_d0_pop", data_out, 16'hFFFF);

    $display("[TB] overflow with N=20");
    writeReg(A_DIV, 16'd1);
    writeReg(A_COUNT, 16'd20);
    writeReg(A_CMD, START);
    idle(277);
    readReg(A_STATUS);
    checkOutput("t3_status_run_ovf", data_out, 16'hC010);
    idle(50);
    readReg(A_STATUS);
    checkOutput("t3_status_idle_ovf", data_out, 16'h8010);
    readReg(A_STATUS);
    checkOutput("t3_status_cleared", data_out, 16'h0010);

    $display("[TB] drain, empty read, push+pop when full");
    for (int i = 0; i < 16; i++) begin
      readReg(A_POP);
      checkOutput("t5_drain", data_out, 16'hFFFF);
    end
    readReg(A_POP);
    checkOutput("t5_pop_empty", data_out, 16'h0000);
    readReg(A_STATUS);
    checkOutput("t5_status_empty", data_out, 16'h0000);
    writeReg(A_COUNT, 16'd17);
    writeReg(A_CMD, START);
    idle(271);
    readReg(A_POP);
    checkOutput("t5_pop_full", data_out, 16'hFFFF);
    readReg(A_STATUS);
    checkOutput("t5_status_full_no_ovf", data_out, 16'h0010);
    for (int i = 0; i < 16; i++) readReg(A_POP);

    $display("[TB] STOP mid-word and restart");
    writeReg(A_COUNT, 16'd2);
    writeReg(A_CMD, START);
    idle(20);
    writeReg(A_CMD, STOP);
    readReg(A_STATUS);
    checkOutput("t4_status_stopped", data_out, 16'h0001);
    writeReg(A_COUNT, 16'd1);
    idle(1);
    writeReg(A_CMD, START);
    idle(2);
    curPin = 1'b0;
    idle(14);
    readReg(A_POP);
    checkOutput("t4_first_word", data_out, 16'hFFFF);
    readReg(A_POP);
    checkOutput("t4_restart_word", data_out, 16'h000F);

    $display("[TB] reset mid-run");
    curPin = 1'b1;
    writeReg(A_COUNT, 16'd5);
    writeReg(A_CMD, START);
    idle(52);
    readReg(A_STATUS);
    checkOutput("t6_status_pre_reset", data_out, 16'h4003);
    applyStimulus(1'b0, 1'b0, 21'd0, 16'd0, curPin, 1'b1);
    checkOutput("t6_dout_after_reset", data_out, 16'h0000);
    checkOutput("t6_nonempty_after_reset", {15'd0, fifo_nonempty}, 16'h0000);
    idle(3);
    readReg(A_STATUS);
    checkOutput("t6_status_after_reset", data_out, 16'h0000);
    writeReg(A_CMD, START);
    idle(2);
    readReg(A_STATUS);
    checkOutput("t6_start_n0_idle", data_out, 16'h0000);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      int op;
      op = int'($urandom_range(0, 99));
      curPin = $urandom_range(0, 1) == 1;
      if (op < 4)       writeReg(A_DIV, 16'($urandom_range(0, 3)));
      else if (op < 8)  writeReg(A_COUNT, 16'($urandom_range(0, 3)));
      else if (op < 11) writeReg(A_CTRL, 16'($urandom_range(0, 3)));
      else if (op < 15) writeReg(A_CMD, START);
      else if (op < 18) writeReg(A_CMD, STOP);
      else if (op < 19) writeReg(A_CMD, 16'($urandom_range(3, 9)));
      else if (op < 30) readReg(A_POP);
      else if (op < 36) readReg(A_STATUS);
      else if (op < 38) readReg(21'(POS + 24));
      else if (op < 39) applyStimulus(1'b0, 1'b0, 21'd0, 16'd0, curPin, 1'b1);
      else              idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
